// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared types and encodings for the multicycle MIPS main controller
//
// Purpose: state enum, opcode/funct codes, ALU operation classes and the
//          encodings of alucontrol, alusrcb and pcsrc used by mc_main_ctrl
//          and mc_alu_decoder.
// Config:  MC_BNE_EN adds the BNEEX state used by the bne opcode.
package mc_pkg;

  // Controller states. BNEEX exists only when bne support is compiled in.
  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_RTYPEEX,
    S_RTYPEWB,
    S_BEQEX,
    S_ADDIEX,
    S_ADDIWB,
`ifdef MC_BNE_EN
    S_JEX,
    S_BNEEX
`else
    S_JEX
`endif
  } state_t;

  // Opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  // Operation class requested by the main FSM from the ALU decoder
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  // alucontrol encodings
  localparam logic [2:0] ALUCTL_ADD = 3'b010;
  localparam logic [2:0] ALUCTL_SUB = 3'b110;
  localparam logic [2:0] ALUCTL_AND = 3'b000;
  localparam logic [2:0] ALUCTL_OR  = 3'b001;
  localparam logic [2:0] ALUCTL_SLT = 3'b111;

  // ALU B-operand select
  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  // Next-PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // True for the two opcodes that go through the address-compute state
  function automatic logic is_mem_op(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mc_alu_decoder.sv
// rtl/mc_alu_decoder.sv - combinational (aluop, funct) to alucontrol decoder
//
// Purpose: turns the FSM's operation class into the ALU control code; for
//          R-type execution the code comes from the funct field.
// Ports:
//   aluop      in   operation class (ADD / SUB / FUNCT)
//   funct      in   6  instr[5:0]
//   alucontrol out  p_aluctl_w  ALU control code
module mc_alu_decoder
  import mc_pkg::*;
#(
  parameter int p_aluctl_w = 3
) (
  input  aluop_t                  aluop,
  input  logic [5:0]              funct,
  output logic [p_aluctl_w-1:0]   alucontrol
);

  logic [2:0] code;

  always_comb begin
    code = ALUCTL_ADD;
    case (aluop)
      ALUOP_ADD: code = ALUCTL_ADD;
      ALUOP_SUB: code = ALUCTL_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FUNCT_ADD: code = ALUCTL_ADD;
          FUNCT_SUB: code = ALUCTL_SUB;
          FUNCT_AND: code = ALUCTL_AND;
          FUNCT_OR:  code = ALUCTL_OR;
          FUNCT_SLT: code = ALUCTL_SLT;
          // Unknown funct still executes (as add) and still writes back.
          default:   code = ALUCTL_ADD;
        endcase
      end
      default: code = ALUCTL_ADD;
    endcase
  end

  assign alucontrol = p_aluctl_w'(code);

endmodule

// File: rtl/mc_main_ctrl.sv
// rtl/mc_main_ctrl.sv - multicycle MIPS main controller (Moore FSM)
//
// Purpose: sequences FETCH/DECODE/execute/writeback and drives the datapath
//          write enables and mux selects; stalls on mem_ready in FETCH,
//          MEMRD and MEMWR.
// Config:  MC_BNE_EN enables bne (op 000101) through BNEEX; otherwise that
//          opcode is decoded as an unknown nop.
// Ports:
//   clk, reset   clock (rising edge), asynchronous active-high reset
//   op, funct    instr[31:26] / instr[5:0] from the IR
//   zero         ALU zero flag, used in the branch states
//   mem_ready    memory completes its access this cycle
//   pcen         PC enable = pcwrite | (branch & cond)
//   irwrite      IR enable
//   regwrite     register file write
//   memwrite     data memory write
//   iord         0: addr=PC, 1: addr=ALUOut
//   memtoreg     writeback from Data reg
//   regdst       1: rd, 0: rt
//   alusrca      0: PC, 1: A
//   alusrcb      00 B, 01 const 4, 10 SignImm, 11 SignImm<<2
//   pcsrc        00 ALUResult, 01 ALUOut, 10 jump target
//   alucontrol   ALU control code from mc_alu_decoder
module mc_main_ctrl
  import mc_pkg::*;
#(
  parameter int p_aluctl_w = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [5:0]            op,
  input  logic [5:0]            funct,
  input  logic                  zero,
  input  logic                  mem_ready,
  output logic                  pcen,
  output logic                  irwrite,
  output logic                  regwrite,
  output logic                  memwrite,
  output logic                  iord,
  output logic                  memtoreg,
  output logic                  regdst,
  output logic                  alusrca,
  output logic [1:0]            alusrcb,
  output logic [1:0]            pcsrc,
  output logic [p_aluctl_w-1:0] alucontrol
);

  state_t state, state_next;
  aluop_t aluop;

  logic pcwrite;
  logic branch;
  logic branch_on_ne;   // branch condition is ~zero instead of zero
  logic irwrite_s;
  logic regwrite_s;
  logic memwrite_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= state_next;
  end

  always_comb begin
    state_next   = state;
    pcwrite      = 1'b0;
    branch       = 1'b0;
    branch_on_ne = 1'b0;
    irwrite_s    = 1'b0;
    regwrite_s   = 1'b0;
    memwrite_s   = 1'b0;
    iord         = 1'b0;
    memtoreg     = 1'b0;
    regdst       = 1'b0;
    alusrca      = 1'b0;
    alusrcb      = SRCB_B;
    pcsrc        = PCSRC_ALU;
    aluop        = ALUOP_ADD;

    case (state)
      S_FETCH: begin
        // PC+4 is computed every cycle but only committed with the IR
        // when the instruction fetch completes.
        alusrcb   = SRCB_FOUR;
        pcwrite   = mem_ready;
        irwrite_s = mem_ready;
        if (mem_ready) state_next = S_DECODE;
      end
      S_DECODE: begin
        // Speculative branch target lands in ALUOut.
        alusrcb = SRCB_IMMSH;
        case (op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_RTYPEEX;
          OP_BEQ:       state_next = S_BEQEX;
          OP_ADDI:      state_next = S_ADDIEX;
          OP_J:         state_next = S_JEX;
`ifdef MC_BNE_EN
          OP_BNE:       state_next = S_BNEEX;
`endif
          default:      state_next = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        if (!is_mem_op(op))  state_next = S_FETCH;
        else if (op == OP_LW) state_next = S_MEMRD;
        else                  state_next = S_MEMWR;
      end
      S_MEMRD: begin
        iord = 1'b1;
        if (mem_ready) state_next = S_MEMWB;
      end
      S_MEMWB: begin
        memtoreg   = 1'b1;
        regwrite_s = 1'b1;
        state_next = S_FETCH;
      end
      S_MEMWR: begin
        // memwrite is held through the stall; memory commits on ready.
        iord       = 1'b1;
        memwrite_s = 1'b1;
        if (mem_ready) state_next = S_FETCH;
      end
      S_RTYPEEX: begin
        alusrca    = 1'b1;
        alusrcb    = SRCB_B;
        aluop      = ALUOP_FUNCT;
        state_next = S_RTYPEWB;
      end
      S_RTYPEWB: begin
        regdst     = 1'b1;
        regwrite_s = 1'b1;
        state_next = S_FETCH;
      end
      S_BEQEX: begin
        alusrca    = 1'b1;
        alusrcb    = SRCB_B;
        aluop      = ALUOP_SUB;
        pcsrc      = PCSRC_ALUOUT;
        branch     = 1'b1;
        state_next = S_FETCH;
      end
`ifdef MC_BNE_EN
      S_BNEEX: begin
        alusrca      = 1'b1;
        alusrcb      = SRCB_B;
        aluop        = ALUOP_SUB;
        pcsrc        = PCSRC_ALUOUT;
        branch       = 1'b1;
        branch_on_ne = 1'b1;
        state_next   = S_FETCH;
      end
`endif
      S_ADDIEX: begin
        alusrca    = 1'b1;
        alusrcb    = SRCB_IMM;
        state_next = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite_s = 1'b1;
        state_next = S_FETCH;
      end
      S_JEX: begin
        pcsrc      = PCSRC_JUMP;
        pcwrite    = 1'b1;
        state_next = S_FETCH;
      end
      default: state_next = S_FETCH;
    endcase
  end

  // The state register already sits in FETCH during reset, but FETCH would
  // still raise pcen/irwrite on mem_ready; reset masks every write enable.
  assign pcen     = ~reset & (pcwrite | (branch & (branch_on_ne ? ~zero : zero)));
  assign irwrite  = ~reset & irwrite_s;
  assign regwrite = ~reset & regwrite_s;
  assign memwrite = ~reset & memwrite_s;

  mc_alu_decoder #(
    .p_aluctl_w(p_aluctl_w)
  ) u_alu_decoder (
    .aluop      (aluop),
    .funct      (funct),
    .alucontrol (alucontrol)
  );

endmodule

// File: tb/tb_mc_main_ctrl.sv
// tb/tb_mc_main_ctrl.sv - self-checking bench for mc_main_ctrl
module tb_mc_main_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       pcen, irwrite, regwrite, memwrite, iord, memtoreg, regdst, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mc_main_ctrl #(.p_aluctl_w(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pcen       (pcen),
    .irwrite    (irwrite),
    .regwrite   (regwrite),
    .memwrite   (memwrite),
    .iord       (iord),
    .memtoreg   (memtoreg),
    .regdst     (regdst),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .pcsrc      (pcsrc),
    .alucontrol (alucontrol)
  );

  typedef struct packed {
    logic       pcen, irwrite, regwrite, memwrite, iord, memtoreg, regdst, alusrca;
    logic [1:0] alusrcb, pcsrc;
  } outs_t;

  typedef struct {
    outs_t      o;
    logic [2:0] alu;
    bit         chk_alu;
    logic       mr;
  } cyc_t;

  // Expected per-cycle behaviour of the instruction currently being run
  cyc_t q[$];

  function automatic outs_t sample();
    outs_t s;
    s.pcen = pcen;  s.irwrite = irwrite;   s.regwrite = regwrite; s.memwrite = memwrite;
    s.iord = iord;  s.memtoreg = memtoreg; s.regdst = regdst;     s.alusrca = alusrca;
    s.alusrcb = alusrcb; s.pcsrc = pcsrc;
    return s;
  endfunction

  function automatic logic [2:0] ref_alu(input logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  function automatic logic rbit();
    return ($urandom & 32'd1) != 0;
  endfunction

  task automatic push(input outs_t o, input logic [2:0] alu, input bit chk, input logic mr);
    cyc_t c;
    c.o = o; c.alu = alu; c.chk_alu = chk; c.mr = mr;
    q.push_back(c);
  endtask

  // Reference: the cycle-by-cycle output sequence of one instruction.
  // fw = cycles memory stalls the fetch, mw = cycles it stalls the data access.
  task automatic build(input logic [5:0] bop, input logic [5:0] bf, input logic bz,
                       input int fw, input int mw);
    outs_t o;
    o = '0; o.alusrcb = 2'b01;
    repeat (fw) push(o, 3'b010, 1, 1'b0);
    o.pcen = 1'b1; o.irwrite = 1'b1;
    push(o, 3'b010, 1, 1'b1);
    o = '0; o.alusrcb = 2'b11;
    push(o, 3'b010, 1, rbit());
    case (bop)
      6'b100011, 6'b101011: begin
        o = '0; o.alusrca = 1'b1; o.alusrcb = 2'b10;
        push(o, 3'b010, 1, rbit());
        o = '0; o.iord = 1'b1; o.memwrite = (bop == 6'b101011);
        repeat (mw) push(o, 3'b000, 0, 1'b0);
        push(o, 3'b000, 0, 1'b1);
        if (bop == 6'b100011) begin
          o = '0; o.memtoreg = 1'b1; o.regwrite = 1'b1;
          push(o, 3'b000, 0, rbit());
        end
      end
      6'b000000: begin
        o = '0; o.alusrca = 1'b1;
        push(o, ref_alu(bf), 1, rbit());
        o = '0; o.regdst = 1'b1; o.regwrite = 1'b1;
        push(o, 3'b000, 0, rbit());
      end
      6'b000100: begin
        o = '0; o.alusrca = 1'b1; o.pcsrc = 2'b01; o.pcen = bz;
        push(o, 3'b110, 1, rbit());
      end
`ifdef MC_BNE_EN
      6'b000101: begin
        o = '0; o.alusrca = 1'b1; o.pcsrc = 2'b01; o.pcen = ~bz;
        push(o, 3'b110, 1, rbit());
      end
`endif
      6'b001000: begin
        o = '0; o.alusrca = 1'b1; o.alusrcb = 2'b10;
        push(o, 3'b010, 1, rbit());
        o = '0; o.regwrite = 1'b1;
        push(o, 3'b000, 0, rbit());
      end
      6'b000010: begin
        o = '0; o.pcsrc = 2'b10; o.pcen = 1'b1;
        push(o, 3'b000, 0, rbit());
      end
      default: ;
    endcase
  endtask

  // Plays the queued cycles (at most limit of them when limit >= 0).
  // Entered and left one time unit after a rising edge.
  task automatic run(input string name, input int limit);
    cyc_t  c;
    outs_t got;
    int    k;
    k = 0;
    while (q.size() > 0 && (limit < 0 || k < limit)) begin
      c = q.pop_front();
      mem_ready = c.mr;
      @(negedge clk);
      got = sample();
      n_checks++;
      if (got !== c.o) begin
        n_fail++;
        $display("FAIL %s cyc%0d outputs got %b required %b", name, k, got, c.o);
      end
      if (c.chk_alu) begin
        n_checks++;
        if (alucontrol !== c.alu) begin
          n_fail++;
          $display("FAIL %s cyc%0d alucontrol got %b required %b", name, k, alucontrol, c.alu);
        end
      end
      @(posedge clk); #1;
      k++;
    end
    q.delete();
  endtask

  task automatic instr(input string name, input logic [5:0] iop, input logic [5:0] ifn,
                       input logic iz, input int fw, input int mw);
    op = iop; funct = ifn; zero = iz;
    q.delete();
    build(iop, ifn, iz, fw, mw);
    run(name, -1);
  endtask

  task automatic test_reset();
    reset = 1'b1; op = 6'b100011; funct = 6'b0; zero = 1'b1; mem_ready = 1'b1;
    #2;
    n_checks++;
    if ({pcen, irwrite, regwrite, memwrite} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_en got %b required 0000", {pcen, irwrite, regwrite, memwrite});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({pcen, irwrite, regwrite, memwrite, iord, alusrcb} !== 7'b0000_0_01) begin
      n_fail++;
      $display("FAIL reset_fetch got %b required 0000001",
               {pcen, irwrite, regwrite, memwrite, iord, alusrcb});
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_lw();
    instr("lw", 6'b100011, 6'($urandom), rbit(), 0, 0);
  endtask

  task automatic test_sw_wait();
    instr("sw_wait", 6'b101011, 6'($urandom), rbit(), 0, 3);
  endtask

  task automatic test_beq();
    instr("beq_z1", 6'b000100, 6'($urandom), 1'b1, 0, 0);
    instr("beq_z0", 6'b000100, 6'($urandom), 1'b0, 1, 0);
  endtask

  task automatic test_rtype();
    logic [5:0] fl[6];
    fl = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000111};
    foreach (fl[i]) instr("rtype", 6'b000000, fl[i], rbit(), 0, 0);
  endtask

  task automatic test_addi_j();
    instr("addi", 6'b001000, 6'($urandom), rbit(), 0, 0);
    instr("j", 6'b000010, 6'($urandom), rbit(), 2, 0);
  endtask

  task automatic test_unknown_op();
    instr("op_3f", 6'b111111, 6'($urandom), 1'b0, 0, 0);
    instr("op_bne_z0", 6'b000101, 6'($urandom), 1'b0, 0, 0);
    instr("op_bne_z1", 6'b000101, 6'($urandom), 1'b1, 0, 0);
  endtask

  task automatic test_reset_mid();
    outs_t exp_f;
    op = 6'b100011; funct = 6'b0; zero = 1'b0;
    q.delete();
    build(6'b100011, 6'b0, 1'b0, 0, 3);
    run("rst_mid_pre", 4);   // now sitting in the memory-read stall
    mem_ready = 1'b0;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({pcen, irwrite, regwrite, memwrite, iord} !== 5'b00000) begin
      n_fail++;
      $display("FAIL rst_mid_async got %b required 00000",
               {pcen, irwrite, regwrite, memwrite, iord});
    end
    @(posedge clk); #1;
    reset = 1'b0;
    exp_f = '0; exp_f.alusrcb = 2'b01;
    @(negedge clk);
    n_checks++;
    if (sample() !== exp_f) begin
      n_fail++;
      $display("FAIL rst_mid_fetch got %b required %b", sample(), exp_f);
    end
    @(posedge clk); #1;
    instr("rst_mid_post", 6'b001000, 6'b0, 1'b0, 0, 0);
  endtask

  task automatic test_back_to_back();
    logic [5:0] ol[8];
    logic [5:0] fl[6];
    logic [5:0] o, f;
    ol = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010, 6'b000101, 6'b0};
    fl = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b0};
    for (int i = 0; i < 60; i++) begin
      o = ol[$urandom_range(7, 0)];
      if (o == 6'b0 && rbit()) o = 6'($urandom);
      f = fl[$urandom_range(5, 0)];
      if (f == 6'b0) f = 6'($urandom);
      instr("b2b", o, f, rbit(), $urandom_range(2, 0), $urandom_range(3, 0));
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw_wait();
    test_beq();
    test_rtype();
    test_addi_j();
    test_unknown_op();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
